// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between instruction fetch (IF)
// and data memory (DM) requesters. Only one access is in flight at a time.
// DM has priority, but alternation under contention keeps IF from starving.
// The owner receives a one-cycle done pulse, and stalls are derived combinationally.
// Optional feature: define MEM_ARB_ALIGN_CHK_EN to reject odd addresses.
// A rejected access skips the memory and pulses err together with the owner's done.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_dm_q, owner_dm_d;  // 1 = DM owns the current access
  logic            last_dm_q, last_dm_d;    // 1 = DM received the most recent grant
  logic            wr_q, wr_d;
  logic            first_q, first_d;        // first ACCESS cycle, the only one with mem_en
  logic            mis_q, mis_d;            // access rejected as misaligned
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     if_rdata_q, if_rdata_d;
  logic [15:0]     dm_rdata_q, dm_rdata_d;
  logic            grant_dm;
  logic [15:0]     sel_addr;

  // DM wins unless it also won last time and IF is waiting.
  assign grant_dm = dm_req & ~(last_dm_q & if_req);
  assign sel_addr = grant_dm ? dm_addr : if_addr;

  // Next-state logic: arbitration, latency countdown and read-data capture.
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    last_dm_d  = last_dm_q;
    wr_d       = wr_q;
    first_d    = first_q;
    mis_d      = mis_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (if_req | dm_req) begin
          state_d    = StAccess;
          owner_dm_d = grant_dm;
          last_dm_d  = grant_dm;
          wr_d       = grant_dm & dm_wr;
          addr_d     = sel_addr;
          if (grant_dm) wdata_d = dm_wdata;
          cnt_d      = CntInit;
          first_d    = 1'b1;
`ifdef MEM_ARB_ALIGN_CHK_EN
          mis_d      = sel_addr[0];
`else
          mis_d      = 1'b0;
`endif
        end
      end
      StAccess: begin
        first_d = 1'b0;
        if (mis_q || (cnt_q == '0)) begin
          state_d = StDone;
          if (!mis_q && !wr_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset aborts any access in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      last_dm_q  <= 1'b0;
      wr_q       <= 1'b0;
      first_q    <= 1'b0;
      mis_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      last_dm_q  <= last_dm_d;
      wr_q       <= wr_d;
      first_q    <= first_d;
      mis_q      <= mis_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = (state_q == StAccess) & first_q & ~mis_q;
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = (state_q == StDone) & ~owner_dm_q;
  assign dm_done   = (state_q == StDone) & owner_dm_q;
  assign if_stall  = if_req & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;
`ifdef MEM_ARB_ALIGN_CHK_EN
  assign err       = (state_q == StDone) & mis_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic.
// A transaction-level schedule model predicts grants, strobes, done pulses and read data.
// A behavioural memory returns valid data only in the access's latency cycle.
module tb_mem_arbiter;
  localparam int unsigned LAT = 4;
`ifdef MEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Behavioural memory
  logic [15:0] mem [logic [15:0]];
  int          mem_age = 0;
  logic [15:0] mem_raddr;

  // Transaction-level schedule model
  bit          m_busy = 0, m_dm = 0, m_wr = 0, m_mis = 0, m_last_dm = 0;
  int          m_en_cyc = 0, m_done_cyc = 0, m_free_at = 0;
  logic [15:0] m_addr, m_wdata, m_rd;
  logic [15:0] e_if_rdata = '0, e_dm_rdata = '0;
  bit          d_now = 0, d_dm = 0;

  // Requester control
  bit          rand_on = 0, if_want = 0, dm_want = 0, if_hold = 0, dm_hold = 0;
  logic [15:0] if_want_addr, dm_want_addr, dm_want_wdata;
  bit          dm_want_wr;
  bit          log_on = 0;
  int          done_log [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 16'h5A5A) + 16'h0101;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 63)) << 1;
    if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
    return a;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_dm_rdata"}, dm_rdata, 0);
    chk({tag, "_if_done"}, if_done, 0);
    chk({tag, "_dm_done"}, dm_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_if_stall"}, if_stall, 0);
    chk({tag, "_dm_stall"}, dm_stall, 0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_last_dm = 0; m_free_at = 0;
    e_if_rdata = '0; e_dm_rdata = '0; mem_age = 0;
  endtask

  // One clock cycle: check outputs, run memory, drive requesters, arbitrate in the model.
  task automatic tick();
    bit exp_en;
    @(posedge clk);
    #1;
    cyc++;
    exp_en = m_busy && (cyc == m_en_cyc) && !m_mis;
    d_now  = m_busy && (cyc == m_done_cyc);
    d_dm   = m_dm;
    chk("mem_en", mem_en, exp_en);
    chk("mem_wr", mem_wr, exp_en && m_wr);
    if (m_busy && cyc >= m_en_cyc) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (d_now && !m_mis && !m_wr) begin
      if (m_dm) e_dm_rdata = m_rd;
      else      e_if_rdata = m_rd;
    end
    chk("if_done", if_done, d_now && !m_dm);
    chk("dm_done", dm_done, d_now && m_dm);
    chk("err", err, d_now && m_mis);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    if (d_now) begin
      m_busy = 0;
      if (log_on) done_log.push_back(dm_done ? 1 : (if_done ? 0 : 2));
    end
    // memory: data valid only in cycle LAT counted from the mem_en cycle
    if (mem_en) begin
      if (mem_wr) mem[mem_addr] = mem_wdata;
      mem_age   = 1;
      mem_raddr = mem_addr;
    end else if (mem_age != 0) begin
      mem_age = (mem_age >= int'(LAT)) ? 0 : mem_age + 1;
    end
    mem_rdata = (mem_age == int'(LAT)) ? rd(mem_raddr) : 16'($urandom);
    // requesters hold until their done, then drop (unless held for back-to-back traffic)
    if (if_req && d_now && !d_dm && !if_hold) if_req = 1'b0;
    else if (!if_req && (if_want || (rand_on && $urandom_range(0, 3) == 0))) begin
      if_addr = if_want ? if_want_addr : rand_addr();
      if_req  = 1'b1;
      if_want = 0;
    end
    if (dm_req && d_now && d_dm && !dm_hold) dm_req = 1'b0;
    else if (!dm_req && (dm_want || (rand_on && $urandom_range(0, 3) == 0))) begin
      dm_addr  = dm_want ? dm_want_addr : rand_addr();
      dm_wr    = dm_want ? dm_want_wr : 1'($urandom_range(0, 1));
      dm_wdata = dm_want ? dm_want_wdata : 16'($urandom);
      dm_req   = 1'b1;
      dm_want  = 0;
    end
    #1;
    chk("if_stall", if_stall, if_req && !(d_now && !d_dm));
    chk("dm_stall", dm_stall, dm_req && !(d_now && d_dm));
    // arbitration in the model
    if (!m_busy && cyc >= m_free_at && (if_req || dm_req)) begin
      m_dm       = dm_req && !(m_last_dm && if_req);
      m_last_dm  = m_dm;
      m_addr     = m_dm ? dm_addr : if_addr;
      m_wr       = m_dm && dm_wr;
      m_wdata    = dm_wdata;
      m_mis      = ALIGN && m_addr[0];
      m_rd       = rd(m_addr);
      m_en_cyc   = cyc + 1;
      m_done_cyc = m_mis ? cyc + 2 : cyc + int'(LAT) + 1;
      m_free_at  = m_done_cyc + 1;
      m_busy     = 1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((m_busy || if_req || dm_req || if_want || dm_want) && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (n < 200) else begin
      n_bad++;
      $error("FAIL %s_drain: observed timeout expected idle", tag);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 0; dm_req = 0; dm_wr = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst0");
    @(negedge clk);
    rst = 1'b0;

    // IF read from reset
    mem[16'h0010] = 16'h1234;
    if_want = 1; if_want_addr = 16'h0010;
    drain("t1");
    chk("t1_if_rdata", if_rdata, 16'h1234);

    // simultaneous IF and DM with last grant IF: DM first
    mem[16'h0100] = 16'hCAFE;
    done_log.delete(); log_on = 1;
    if_want = 1; if_want_addr = 16'h0020;
    dm_want = 1; dm_want_addr = 16'h0100; dm_want_wr = 0; dm_want_wdata = 16'h0;
    drain("t2");
    log_on = 0;
    chk("t2_count", 16'(done_log.size()), 2);
    if (done_log.size() == 2) begin
      chk("t2_first_dm", 16'(done_log[0]), 1);
      chk("t2_second_if", 16'(done_log[1]), 0);
    end
    chk("t2_dm_rdata", dm_rdata, 16'hCAFE);

    // DM write leaves dm_rdata untouched
    dm_want = 1; dm_want_addr = 16'h0200; dm_want_wr = 1; dm_want_wdata = 16'hBEEF;
    drain("t3");
    chk("t3_dm_rdata_kept", dm_rdata, 16'hCAFE);
    chk("t3_mem_word", rd(16'h0200), 16'hBEEF);

    // restore last grant = IF, then contend continuously for six accesses
    if_want = 1; if_want_addr = 16'h0030;
    drain("t4pre");
    done_log.delete(); log_on = 1;
    if_hold = 1; dm_hold = 1;
    if_want = 1; if_want_addr = 16'h0040;
    dm_want = 1; dm_want_addr = 16'h0050; dm_want_wr = 0; dm_want_wdata = 16'h0;
    for (int n = 0; n < 100 && done_log.size() < 6; n++) tick();
    if_hold = 0; dm_hold = 0;
    drain("t4");
    log_on = 0;
    chk("t4_count_ge6", 16'(done_log.size() >= 6), 1);
    for (int i = 0; i < 6 && i < done_log.size(); i++)
      chk($sformatf("t4_order%0d", i), 16'(done_log[i]), (i % 2 == 0) ? 16'd1 : 16'd0);

    // reset in cycle 2 of an IF access
    if_want = 1; if_want_addr = 16'h0060;
    tick(); tick(); tick();
    rst = 1'b1; if_req = 0; dm_req = 0;
    #1;
    reset_check("t5_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if_want = 1; if_want_addr = 16'h0060;
    drain("t5");
    chk("t5_if_rdata", if_rdata, rd(16'h0060));

    // odd DM address: rejected with err when checking is built in, else issued as-is
    dm_want = 1; dm_want_addr = 16'h0101; dm_want_wr = 0; dm_want_wdata = 16'h0;
    drain("t6");

    // random traffic
    rand_on = 1;
    repeat (400) tick();
    rand_on = 0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
